// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared definitions for the 8085 machine-cycle sequencer.
//   - ienb / chk_i bit indices
//   - sequencer state encoding
//   - bus status codes
//   - next machine-cycle helper
package core_seq_pkg;

  localparam int IENBSIZE = 7;
  localparam int INSTSIZE = 17;
  localparam int INFO_CYC = 4;

  // ienb bit positions
  localparam int IENB_RRD = 0;
  localparam int IENB_RWR = 1;
  localparam int IENB_COD = 2;
  localparam int IENB_DAT = 3;
  localparam int IENB_PC_ = 4;
  localparam int IENB_PD_ = 5;
  localparam int IENB_NXT = 6;

  // chk_i bit positions / field bases
  localparam int INST_GO6   = 0;
  localparam int INST_DAD   = 1;
  localparam int INST_HLT   = 2;
  localparam int INST_DIO   = 3;
  localparam int INST_CY_LO = 4;
  localparam int INST_RW_LO = 8;
  localparam int INST_CD_LO = 12;
  localparam int INST_CCC   = 16;

  typedef enum logic [3:0] {
    ST_RST = 4'd0,
    ST_T1  = 4'd1,
    ST_T2  = 4'd2,
    ST_TW  = 4'd3,
    ST_T3  = 4'd4,
    ST_T4  = 4'd5,
    ST_T5  = 4'd6,
    ST_T6  = 4'd7,
    ST_TH  = 4'd8
  } state_t;

  localparam logic [1:0] S_FETCH = 2'b11;
  localparam logic [1:0] S_READ  = 2'b10;
  localparam logic [1:0] S_WRITE = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b00;

  // Machine cycle following m (1..4). M(m+1) runs only if CY[m-1] is set;
  // otherwise the instruction is finished and the next one starts at M1.
  function automatic logic [2:0] next_mcyc(input logic [2:0] m, input logic [3:0] cy);
    logic [1:0] k;
    k = m[1:0] - 2'd1;
    if (m >= 3'd1 && m <= 3'd4 && cy[k])
      return m + 3'd1;
    else
      return 3'd1;
  endfunction

endpackage

// File: rtl/core_seq_dec.sv
// core_seq_dec: combinational output decode for the sequencer.
// Ports:
//   state  in  4   current T-state (state_t encoding)
//   mcyc   in  3   current machine cycle (0 in reset, 1..5)
//   info_q in  17  instruction info latched at M1 T4
//   chk_i  in  17  live instruction info (only looked at during M1 T4)
//   ienb   out 7   datapath enables
//   ale, rd_, wr_, iom, s1s0, hlt  bus controls / status
module core_seq_dec
  import core_seq_pkg::*;
(
  input  logic [3:0]          state,
  input  logic [2:0]          mcyc,
  input  logic [INSTSIZE-1:0] info_q,
  input  logic [INSTSIZE-1:0] chk_i,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                iom,
  output logic [1:0]          s1s0,
  output logic                hlt
);

  logic [1:0]          k;
  logic [INFO_CYC-1:0] rw;
  logic [INFO_CYC-1:0] cd;
  logic                is_m1;
  logic                is_mn;
  logic                mn_wr;
  logic                rd_cyc;
  logic                reg_op;
  logic                bus_cyc;
  logic                unused_bits;

  // Mn uses field bit k = n-2; the low two bits of mcyc map 2,3,4,5 -> 0,1,2,3.
  assign k       = mcyc[1:0] - 2'd2;
  assign rw      = info_q[INST_RW_LO +: INFO_CYC];
  assign cd      = info_q[INST_CD_LO +: INFO_CYC];
  assign is_m1   = (mcyc == 3'd1);
  assign is_mn   = (mcyc >= 3'd2) && (mcyc <= 3'd5);
  assign mn_wr   = is_mn && rw[k];
  assign rd_cyc  = is_m1 || (is_mn && !rw[k]);
  assign bus_cyc = (state != ST_RST) && (state != ST_TH);

  // The register-op strobes in M1 T4 depend on the instruction being decoded
  // right now; info_q is only loaded at the end of that same T4.
  assign reg_op  = !chk_i[INST_HLT] && !chk_i[INST_GO6] && !chk_i[INST_CY_LO];

  assign unused_bits = ^{chk_i, info_q[INST_DAD], info_q[INST_CCC],
                         info_q[INST_GO6], info_q[INST_HLT], info_q[INST_CY_LO +: INFO_CYC]};

  always_comb begin
    ienb = '0;
    ale  = 1'b0;
    rd_  = 1'b1;
    wr_  = 1'b1;
    iom  = 1'b0;
    s1s0 = S_HALT;
    hlt  = 1'b0;

    // Status, address source and IO qualifier are levels for the whole M-cycle.
    if (bus_cyc) begin
      s1s0 = is_m1 ? S_FETCH : (mn_wr ? S_WRITE : S_READ);
      ienb[IENB_PD_] = is_mn && cd[k];
      ienb[IENB_NXT] = (mcyc == 3'd3) || (mcyc == 3'd5);
      iom            = (mcyc == 3'd3) && info_q[INST_DIO];
    end

    case (state)
      ST_T1: ale = 1'b1;
      ST_T2: begin
        rd_ = ~rd_cyc;
        wr_ = ~mn_wr;
        ienb[IENB_RRD] = mn_wr;
      end
      ST_TW: begin
        rd_ = ~rd_cyc;
        wr_ = ~mn_wr;
      end
      ST_T3: begin
        rd_ = ~rd_cyc;
        wr_ = ~mn_wr;
        ienb[IENB_COD] = is_m1;
        ienb[IENB_PC_] = is_m1 || (is_mn && !cd[k]);
        ienb[IENB_RRD] = mn_wr;
        ienb[IENB_RWR] = is_mn && !mn_wr;
      end
      ST_T4: begin
        ienb[IENB_RRD] = is_m1 && reg_op;
        ienb[IENB_RWR] = is_m1 && reg_op;
      end
      ST_TH: hlt = 1'b1;
      default: ;
    endcase

    ienb[IENB_DAT] = 1'b0;
  end

endmodule

// File: rtl/core_seq.sv
// core_seq: machine-cycle / T-state sequencer for the 8085 core.
// Ports:
//   clk   in  1   system clock
//   rst   in  1   asynchronous active-high reset
//   chk_i in  17  decoded instruction info (valid from M1 T4)
//   rdy   in  1   bus ready, sampled at end of T2 and each TW
//   ienb  out 7   datapath enables
//   ale   out 1   address latch enable
//   rd_   out 1   read strobe, active-low
//   wr_   out 1   write strobe, active-low
//   iom   out 1   1 = IO cycle
//   s1s0  out 2   bus status
//   mcyc  out 3   current machine cycle (0 in reset)
//   hlt   out 1   halted
//
// state | meaning
// RST   | in reset, bus idle
// T1    | address out, ale high
// T2    | strobe asserted, rdy sampled
// TW    | wait state, strobe held until rdy
// T3    | data transfer, datapath strobes
// T4    | M1 decode, chk_i latched at its end
// T5    | extra M1 clock for 6T instructions
// T6    | second extra M1 clock
// TH    | halted until reset
module core_seq
  import core_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                rdy,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                iom,
  output logic [1:0]          s1s0,
  output logic [2:0]          mcyc,
  output logic                hlt
);

  state_t              state;
  logic [INSTSIZE-1:0] info_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RST;
      mcyc   <= 3'd0;
      info_q <= '0;
    end else begin
      case (state)
        ST_RST: begin
          state <= ST_T1;
          mcyc  <= 3'd1;
        end
        ST_T1: state <= ST_T2;
        ST_T2: state <= rdy ? ST_T3 : ST_TW;
        ST_TW: state <= rdy ? ST_T3 : ST_TW;
        ST_T3: begin
          if (mcyc == 3'd1) begin
            state <= ST_T4;
          end else begin
            state <= ST_T1;
            mcyc  <= next_mcyc(mcyc, info_q[INST_CY_LO +: INFO_CYC]);
          end
        end
        ST_T4: begin
          info_q <= chk_i;
          if (chk_i[INST_HLT]) begin
            state <= ST_TH;
          end else if (chk_i[INST_GO6]) begin
            state <= ST_T5;
          end else begin
            state <= ST_T1;
            mcyc  <= next_mcyc(3'd1, chk_i[INST_CY_LO +: INFO_CYC]);
          end
        end
        ST_T5: state <= ST_T6;
        ST_T6: begin
          state <= ST_T1;
          mcyc  <= next_mcyc(3'd1, info_q[INST_CY_LO +: INFO_CYC]);
        end
        ST_TH: state <= ST_TH;
        default: begin
          state <= ST_RST;
          mcyc  <= 3'd0;
        end
      endcase
    end
  end

  core_seq_dec u_dec (
    .state  (state),
    .mcyc   (mcyc),
    .info_q (info_q),
    .chk_i  (chk_i),
    .ienb   (ienb),
    .ale    (ale),
    .rd_    (rd_),
    .wr_    (wr_),
    .iom    (iom),
    .s1s0   (s1s0),
    .hlt    (hlt)
  );

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: builds the expected per-clock bus trace of each
// instruction from its chk_i fields and compares it cycle by cycle.
module tb_core_seq;

  localparam logic [6:0] M_RRD = 7'h01;
  localparam logic [6:0] M_RWR = 7'h02;
  localparam logic [6:0] M_COD = 7'h04;
  localparam logic [6:0] M_PC  = 7'h10;
  localparam logic [6:0] M_PD  = 7'h20;
  localparam logic [6:0] M_NXT = 7'h40;

  // {ienb, ale, rd_, wr_, iom, s1s0, mcyc, hlt}
  localparam logic [16:0] RST_V = {7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0};

  logic        clk;
  logic        rst;
  logic [16:0] chk_i;
  logic        rdy;
  logic [6:0]  ienb;
  logic        ale, rd_, wr_, iom, hlt;
  logic [1:0]  s1s0;
  logic [2:0]  mcyc;
  logic [16:0] obs;

  int          checks = 0;
  int          errors = 0;
  string       tag;
  int          w[5];
  logic [17:0] q[$];   // {rdy to drive, expected outputs}

  core_seq dut (
    .clk   (clk),
    .rst   (rst),
    .chk_i (chk_i),
    .rdy   (rdy),
    .ienb  (ienb),
    .ale   (ale),
    .rd_   (rd_),
    .wr_   (wr_),
    .iom   (iom),
    .s1s0  (s1s0),
    .mcyc  (mcyc),
    .hlt   (hlt)
  );

  assign obs = {ienb, ale, rd_, wr_, iom, s1s0, mcyc, hlt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [16:0] e, input int idx);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc%0d observed=%h expected=%h", tag, idx, obs, e);
    end
  endtask

  task automatic push(input logic [6:0] ie, input logic a, input logic r, input logic wv,
                      input logic io, input logic [1:0] s, input logic [2:0] m,
                      input logic h, input logic ry);
    q.push_back({ry, ie, a, r, wv, io, s, m, h});
  endtask

  task automatic clear_w();
    for (int i = 0; i < 5; i++) w[i] = 0;
  endtask

  // Expected trace of one instruction, straight from the timing rules.
  task automatic build(input logic [16:0] c);
    logic [3:0] cy, rw, cd;
    logic       regop, wrc, io;
    logic [6:0] lvl;
    logic [1:0] st;
    cy = c[7:4];
    rw = c[11:8];
    cd = c[15:12];
    regop = !c[2] && !c[0] && !cy[0];
    q.delete();
    push(7'h00, 1, 1, 1, 0, 2'b11, 3'd1, 0, 1);
    push(7'h00, 0, 0, 1, 0, 2'b11, 3'd1, 0, w[0] == 0);
    for (int j = 0; j < w[0]; j++) push(7'h00, 0, 0, 1, 0, 2'b11, 3'd1, 0, j == w[0] - 1);
    push(M_COD | M_PC, 0, 0, 1, 0, 2'b11, 3'd1, 0, 1);
    push(regop ? (M_RRD | M_RWR) : 7'h00, 0, 1, 1, 0, 2'b11, 3'd1, 0, 1);
    if (c[2]) begin
      for (int j = 0; j < 20; j++) push(7'h00, 0, 1, 1, 0, 2'b00, 3'd1, 1, 1);
      return;
    end
    if (c[0]) begin
      push(7'h00, 0, 1, 1, 0, 2'b11, 3'd1, 0, 1);
      push(7'h00, 0, 1, 1, 0, 2'b11, 3'd1, 0, 1);
    end
    for (int n = 2; n <= 5; n++) begin
      if (!cy[n-2]) break;
      wrc = rw[n-2];
      st  = wrc ? 2'b01 : 2'b10;
      lvl = (cd[n-2] ? M_PD : 7'h00) | ((n == 3 || n == 5) ? M_NXT : 7'h00);
      io  = (n == 3) && c[3];
      push(lvl, 1, 1, 1, io, st, 3'(n), 0, 1);
      push(lvl | (wrc ? M_RRD : 7'h00), 0, wrc, !wrc, io, st, 3'(n), 0, w[n-1] == 0);
      for (int j = 0; j < w[n-1]; j++)
        push(lvl, 0, wrc, !wrc, io, st, 3'(n), 0, j == w[n-1] - 1);
      push(lvl | (wrc ? M_RRD : M_RWR) | (cd[n-2] ? 7'h00 : M_PC), 0, wrc, !wrc, io, st, 3'(n), 0, 1);
    end
  endtask

  // Walks the expected trace; stop >= 0 checks only the first stop cycles.
  task automatic run(input string name, input logic [16:0] c, input int stop);
    tag = name;
    build(c);
    for (int i = 0; i < q.size(); i++) begin
      if (stop >= 0 && i >= stop) break;
      @(negedge clk);
      if (i == 0) chk_i = c;
      check(q[i][16:0], i);
      rdy = q[i][17];
    end
  endtask

  // Reset must take effect immediately, without a clock edge.
  task automatic rst_pulse(input string name);
    tag = name;
    rst = 1'b1;
    #1;
    check(RST_V, -1);
    @(negedge clk);
    check(RST_V, -2);
    rst   = 1'b0;
    rdy   = 1'b1;
    chk_i = '0;
  endtask

  initial begin
    logic [16:0] c;
    int          ncy;
    rst   = 1'b1;
    chk_i = '0;
    rdy   = 1'b1;
    clear_w();
    tag = "reset";
    repeat (2) begin
      @(negedge clk);
      check(RST_V, 0);
    end
    rst = 1'b0;

    run("nop0", 17'h00000, -1);
    run("nop1", 17'h00000, -1);
    run("nop2", 17'h00000, -1);
    run("mvi_b", 17'h00010, -1);
    run("mov_m_a", 17'h01110, -1);
    w[1] = 2;
    run("mvi_wait", 17'h00010, -1);
    clear_w();
    run("inx", 17'h00001, -1);
    run("out", 17'h00238, -1);
    run("nop3", 17'h00000, -1);

    run("mvi_cut", 17'h00010, 6);
    rst_pulse("rst_m2t2");
    run("nop_after_rst", 17'h00000, -1);

    for (int t = 0; t < 40; t++) begin
      c = 17'(($urandom & 32'h1FFFF));
      c[2] = 1'b0;
      ncy = $urandom_range(0, 4);
      c[7:4] = 4'((1 << ncy) - 1);
      for (int i = 0; i < 5; i++)
        w[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run($sformatf("rand%0d_%h", t, c), c, -1);
    end
    clear_w();

    run("halt", 17'h00004, -1);
    rst_pulse("rst_th");
    run("nop_final", 17'h00000, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
